// File: rtl/main_control_pkg.sv
// Shared encodings for the multicycle main control FSM and the ALU control unit.
package main_control_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ORIEX   = 4'd10,
        IMMWB   = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ORI   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle CPU main controller: Moore FSM with mem_ready gating on FETCH
// strobes and a combinational branch-qualified PC enable.
module main_control_fsm
    import main_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [1:0] alu_opcode,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        pc_src     = PCSRC_ALU;
        alu_opcode = ALUOP_FUNCT;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_opcode = ALUOP_ADD;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                alu_opcode = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ORI:       state_d = ORIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_opcode = ALUOP_ADD;
                state_d    = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alu_src_a  = 1'b1;
                alu_opcode = ALUOP_FUNCT;
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BEQEX: begin
                alu_src_a  = 1'b1;
                alu_opcode = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                branch     = 1'b1;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_opcode = ALUOP_ADD;
                state_d    = IMMWB;
            end
            ORIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_opcode = ALUOP_ORI;
                state_d    = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
            end
            JEX: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        pc_en = pc_write | (branch & zero);

        // The state register already sits in FETCH during reset; only the strobes need masking.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            pc_en      = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: a per-cycle vector table plus an
// asynchronous reset hit in the middle of a load.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_opcode;
    logic       pc_en, illegal_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .alu_opcode (alu_opcode),
        .illegal_op (illegal_op)
    );

    // Packed view: {mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
    //               alu_src_a, alu_src_b[1:0], pc_src[1:0], pc_en, alu_opcode[1:0], illegal_op}
    logic [15:0] outs;
    assign outs = {mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, pc_src, pc_en, alu_opcode, illegal_op};

    localparam logic [15:0] E_RESET   = 16'b0_0_0_0_0_0_0_0_01_00_0_11_0;
    localparam logic [15:0] E_FWAIT   = 16'b1_0_0_0_0_0_0_0_01_00_0_11_0;
    localparam logic [15:0] E_FRDY    = 16'b1_0_0_1_0_0_0_0_01_00_1_11_0;
    localparam logic [15:0] E_DECODE  = 16'b0_0_0_0_0_0_0_0_11_00_0_11_0;
    localparam logic [15:0] E_DECILL  = 16'b0_0_0_0_0_0_0_0_11_00_0_11_1;
    localparam logic [15:0] E_MEMADR  = 16'b0_0_0_0_0_0_0_1_10_00_0_11_0;
    localparam logic [15:0] E_MEMRD   = 16'b1_0_1_0_0_0_0_0_00_00_0_00_0;
    localparam logic [15:0] E_MEMWB   = 16'b0_0_0_0_1_0_1_0_00_00_0_00_0;
    localparam logic [15:0] E_MEMWR   = 16'b1_1_1_0_0_0_0_0_00_00_0_00_0;
    localparam logic [15:0] E_RTYPEEX = 16'b0_0_0_0_0_0_0_1_00_00_0_00_0;
    localparam logic [15:0] E_ALUWB   = 16'b0_0_0_0_1_1_0_0_00_00_0_00_0;
    localparam logic [15:0] E_BEQT    = 16'b0_0_0_0_0_0_0_1_00_01_1_01_0;
    localparam logic [15:0] E_BEQN    = 16'b0_0_0_0_0_0_0_1_00_01_0_01_0;
    localparam logic [15:0] E_ADDIEX  = 16'b0_0_0_0_0_0_0_1_10_00_0_11_0;
    localparam logic [15:0] E_ORIEX   = 16'b0_0_0_0_0_0_0_1_10_00_0_10_0;
    localparam logic [15:0] E_IMMWB   = 16'b0_0_0_0_1_0_0_0_00_00_0_00_0;
    localparam logic [15:0] E_JEX     = 16'b0_0_0_0_0_0_0_0_00_10_1_00_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  opcode;
        logic        zero;
        logic        mem_ready;
        logic [15:0] exp;
        logic [63:0] tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [15:0] e, input logic [63:0] t);
        vec_t v;
        v.rst = r; v.opcode = op; v.zero = z; v.mem_ready = rdy; v.exp = e; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [15:0] exp, input logic [63:0] tag);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got outputs=%b required=%b", tag, outs, exp);
        end else begin
            $display("ok   %s: outputs=%b", tag, outs);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b0;

        // Each row: inputs held for one cycle, outputs checked before that cycle's edge.
        add(1, LW,   0, 1, E_RESET,   "rst_rdy");
        add(0, LW,   0, 0, E_FWAIT,   "first_f");
        add(0, LW,   0, 1, E_FRDY,    "lw_f");
        add(0, LW,   0, 1, E_DECODE,  "lw_dec");
        add(0, LW,   0, 1, E_MEMADR,  "lw_adr");
        add(0, LW,   0, 1, E_MEMRD,   "lw_rd");
        add(0, LW,   0, 1, E_MEMWB,   "lw_wb");
        add(0, SW,   0, 1, E_FRDY,    "sw_f");
        add(0, SW,   0, 0, E_DECODE,  "sw_dec");
        add(0, SW,   0, 0, E_MEMADR,  "sw_adr");
        add(0, SW,   0, 0, E_MEMWR,   "sw_wr0");
        add(0, SW,   0, 0, E_MEMWR,   "sw_wr1");
        add(0, SW,   0, 0, E_MEMWR,   "sw_wr2");
        add(0, SW,   0, 1, E_MEMWR,   "sw_wr3");
        add(0, BEQ,  1, 1, E_FRDY,    "beq1_f");
        add(0, BEQ,  1, 1, E_DECODE,  "beq1_dc");
        add(0, BEQ,  1, 0, E_BEQT,    "beq1_ex");
        add(0, BEQ,  0, 1, E_FRDY,    "beq0_f");
        add(0, BEQ,  0, 0, E_DECODE,  "beq0_dc");
        add(0, BEQ,  0, 1, E_BEQN,    "beq0_ex");
        add(0, RT,   0, 1, E_FRDY,    "rt_f");
        add(0, RT,   0, 1, E_DECODE,  "rt_dec");
        add(0, RT,   0, 1, E_RTYPEEX, "rt_ex");
        add(0, RT,   0, 1, E_ALUWB,   "rt_wb");
        add(0, ORI,  0, 1, E_FRDY,    "ori_f");
        add(0, ORI,  0, 1, E_DECODE,  "ori_dec");
        add(0, ORI,  0, 1, E_ORIEX,   "ori_ex");
        add(0, ORI,  0, 1, E_IMMWB,   "ori_wb");
        add(0, ADDI, 0, 1, E_FRDY,    "addi_f");
        add(0, ADDI, 0, 1, E_DECODE,  "addi_dc");
        add(0, ADDI, 0, 1, E_ADDIEX,  "addi_ex");
        add(0, ADDI, 0, 1, E_IMMWB,   "addi_wb");
        add(0, JMP,  0, 1, E_FRDY,    "j_f");
        add(0, JMP,  0, 1, E_DECODE,  "j_dec");
        add(0, JMP,  0, 1, E_JEX,     "j_ex");
        add(0, BAD,  0, 1, E_FRDY,    "ill_f");
        add(0, BAD,  0, 1, E_DECILL,  "ill_dec");
        add(0, BAD,  0, 0, E_FWAIT,   "ill_post");
        add(0, LW,   0, 1, E_FRDY,    "lw2_f");
        add(0, LW,   0, 0, E_DECODE,  "lw2_dec");
        add(0, LW,   0, 0, E_MEMADR,  "lw2_adr");
        add(0, LW,   0, 0, E_MEMRD,   "lw2_rd0");

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; opcode = vecs[i].opcode;
            zero = vecs[i].zero; mem_ready = vecs[i].mem_ready;
            #1;
            check(vecs[i].exp, vecs[i].tag);
            @(posedge clk);
            #1;
        end

        // Still waiting in MEMRD; hit reset between edges and expect FETCH outputs at once.
        mem_ready = 1'b0;
        #1;
        check(E_MEMRD, "rd_wait");
        rst = 1'b1;
        #1;
        check(E_RESET, "rst_mid");
        @(posedge clk);
        #1;
        check(E_RESET, "rst_hold");
        rst = 1'b0;
        #1;
        check(E_FWAIT, "rst_rel");
        mem_ready = 1'b1;
        #1;
        check(E_FRDY, "rel_rdy");
        @(posedge clk);
        #1;
        check(E_DECODE, "rel_dec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameters: none; all encodings come from main_control_pkg.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  instruction-register opcode field, valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled combinationally in BEQEX.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 mem_req  output  1  memory access request, held until mem_ready.
REQ-008 mem_we  output  1  write qualifier for mem_req.
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes and selects.
REQ-011 alu_src_b  output  2  00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-012 pc_src  output  2  00 = ALU, 01 = ALU output register, 10 = jump target.
REQ-013 pc_en  output  1  PC load enable, equal to pc_write | (branch & zero).
REQ-014 alu_opcode  output  2  feeds the ALU control unit: 11 = ADD, 01 = SUB, 10 = ORI-class, 00 = decode from funct.
REQ-015 illegal_op  output  1  one-cycle pulse for an unsupported opcode.

Function
REQ-016 Opcodes SHALL be: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, ORI 001101, J 000010.
REQ-017 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ORIEX, IMMWB, JEX.
REQ-018 Unlisted outputs SHALL be 0 in every state; this is a Moore machine except for the mem_ready gating and pc_en.
REQ-019 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_opcode=ADD and pc_src=00.
REQ-020 FETCH SHALL assert ir_write and pc_write only in the cycle where mem_ready=1, then go to DECODE; otherwise it stays in FETCH.
REQ-021 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_opcode=ADD.
REQ-022 DECODE SHALL branch as follows: LW/SW to MEMADR, RTYPE to RTYPEEX, BEQ to BEQEX, ADDI to ADDIEX, ORI to ORIEX, J to JEX; any other opcode pulses illegal_op and returns to FETCH.
REQ-023 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and ADD, then go to MEMRD for LW or MEMWR for SW.
REQ-024 MEMRD SHALL drive mem_req=1 and iord=1, holding until mem_ready, then go to MEMWB.
REQ-025 MEMWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-026 MEMWR SHALL drive mem_req=1, mem_we=1 and iord=1, holding until mem_ready, then go to FETCH.
REQ-027 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00 and alu_opcode=00, then go to ALUWB.
REQ-028 ALUWB SHALL drive reg_write=1 and reg_dst=1, then go to FETCH.
REQ-029 BEQEX SHALL drive alu_src_a=1, alu_src_b=00, SUB, pc_src=01 and branch=1, then go to FETCH; pc_en=zero in that cycle.
REQ-030 ADDIEX and ORIEX SHALL both drive alu_src_a=1 and alu_src_b=10; ADDIEX uses ADD, ORIEX uses ORI-class; both go to IMMWB.
REQ-031 IMMWB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-032 JEX SHALL drive pc_src=10 and pc_write=1, then go to FETCH.
REQ-033 mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-034 An encoding that is not a defined state SHALL recover to FETCH on the next edge.

Reset
REQ-035 rst assertion SHALL force FETCH immediately, including mid-access or mid-wait.
REQ-036 While rst=1, mem_req, mem_we, ir_write, reg_write, pc_en and illegal_op SHALL be 0; selects take their FETCH values.
REQ-037 The first FETCH request SHALL appear in the first cycle after rst deasserts.

Structure
REQ-038 main_control_pkg SHALL hold the state enum, the opcode localparams, the alu_opcode encodings (shared with the ALU control unit) and the alu_src_b/pc_src encodings.
REQ-039 The block SHALL be one module (state register plus combinational next-state/output logic) with no sub-module.

Verification
REQ-040 Reset, then ready=1 in FETCH with opcode 100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH in 5 cycles; reg_write=1 and mem_to_reg=1 in MEMWB.
REQ-041 SW with mem_ready held low 3 cycles in MEMWR -> mem_req=1 and mem_we=1 stable for 4 cycles, then FETCH.
REQ-042 BEQ run twice, zero=1 then zero=0 -> pc_en=1 then 0 in BEQEX; alu_opcode=01 both times.
REQ-043 RTYPE -> alu_opcode=00 in RTYPEEX and reg_dst=1 in ALUWB; ORI -> alu_opcode=10 in ORIEX.
REQ-044 Opcode 111111 -> illegal_op=1 for exactly one cycle, then FETCH; rst asserted mid-MEMRD -> FETCH with mem_req=0 immediately.
